// File: rtl/multicycle_pkg.sv
// Shared encodings for the multicycle controller: state codes, opcodes and
// the datapath mux/ALU select values driven by the output decoder.
package multicycle_pkg;

    typedef enum logic [3:0] {
        ST_FETCH  = 4'd0,
        ST_DECODE = 4'd1,
        ST_MEMADR = 4'd2,
        ST_MEMRD  = 4'd3,
        ST_MEMWB  = 4'd4,
        ST_MEMWR  = 4'd5,
        ST_EXEC   = 4'd6,
        ST_RWB    = 4'd7,
        ST_BRANCH = 4'd8,
        ST_JUMP   = 4'd9,
        ST_ADDIEX = 4'd10,
        ST_ADDIWB = 4'd11,
        ST_ERROR  = 4'd15
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // Dispatch target out of DECODE; anything unrecognised is trapped.
    function automatic state_e decode_target(input logic [5:0] op);
        state_e nxt;
        case (op)
            OP_RTYPE:     nxt = ST_EXEC;
            OP_LW, OP_SW: nxt = ST_MEMADR;
            OP_BEQ:       nxt = ST_BRANCH;
            OP_J:         nxt = ST_JUMP;
            OP_ADDI:      nxt = ST_ADDIEX;
            default:      nxt = ST_ERROR;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/multicycle_out_decode.sv
// Combinational control-word decode from the current state; only FETCH
// looks at mem_ready so IR/PC are written in the cycle the fetch completes.
module multicycle_out_decode
    import multicycle_pkg::*;
(
    input  logic [3:0] state,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemtoReg,
    output logic       RegDst,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] PCSource,
    output logic       illegal
);

    // Per-state control word; unused encodings leave everything deasserted.
    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemtoReg    = 1'b0;
        RegDst      = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = SRCB_REG;
        ALUOp       = ALUOP_ADD;
        PCSource    = PCSRC_ALU;
        illegal     = 1'b0;
        case (state)
            ST_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = SRCB_FOUR;
                IRWrite = mem_ready;
                PCWrite = mem_ready;
            end
            ST_DECODE: begin
                ALUSrcB = SRCB_IMM_SH;
            end
            ST_MEMADR, ST_ADDIEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
            end
            ST_MEMRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            ST_MEMWB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
            end
            ST_MEMWR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
            end
            ST_EXEC: begin
                ALUSrcA = 1'b1;
                ALUOp   = ALUOP_FUNCT;
            end
            ST_RWB: begin
                RegDst   = 1'b1;
                RegWrite = 1'b1;
            end
            ST_BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUOp       = ALUOP_SUB;
                PCWriteCond = 1'b1;
                PCSource    = PCSRC_ALUOUT;
            end
            ST_JUMP: begin
                PCWrite  = 1'b1;
                PCSource = PCSRC_JUMP;
            end
            ST_ADDIWB: begin
                RegWrite = 1'b1;
            end
            ST_ERROR: begin
                illegal = 1'b1;
            end
            default: begin
                illegal = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS-style control FSM: state register and next-state logic,
// with the control word decoded from the state by multicycle_out_decode.
module multicycle_control
    import multicycle_pkg::*;
#(
    parameter int OPW = 6
) (
    input  logic           clock,
    input  logic           reset,
    input  logic [OPW-1:0] opcode,
    input  logic           mem_ready,
    output logic           PCWrite,
    output logic           PCWriteCond,
    output logic           IorD,
    output logic           MemRead,
    output logic           MemWrite,
    output logic           IRWrite,
    output logic           MemtoReg,
    output logic           RegDst,
    output logic           RegWrite,
    output logic           ALUSrcA,
    output logic [1:0]     ALUSrcB,
    output logic [1:0]     ALUOp,
    output logic [1:0]     PCSource,
    output logic           illegal,
    output logic [3:0]     state
);

    state_e     state_q;
    state_e     state_d;
    logic [5:0] op_s;

    // The opcode field is the top six bits of whatever the IR presents.
    assign op_s  = opcode[OPW-1 -: 6];
    assign state = state_q;

    // Next-state selection; memory states wait on mem_ready, ERROR is sticky.
    always_comb begin
        state_d = ST_ERROR;
        case (state_q)
            ST_FETCH:  state_d = mem_ready ? ST_DECODE : ST_FETCH;
            ST_DECODE: state_d = decode_target(op_s);
            ST_MEMADR: state_d = (op_s == OP_LW) ? ST_MEMRD : ST_MEMWR;
            ST_MEMRD:  state_d = mem_ready ? ST_MEMWB : ST_MEMRD;
            ST_MEMWB:  state_d = ST_FETCH;
            ST_MEMWR:  state_d = mem_ready ? ST_FETCH : ST_MEMWR;
            ST_EXEC:   state_d = ST_RWB;
            ST_RWB:    state_d = ST_FETCH;
            ST_BRANCH: state_d = ST_FETCH;
            ST_JUMP:   state_d = ST_FETCH;
            ST_ADDIEX: state_d = ST_ADDIWB;
            ST_ADDIWB: state_d = ST_FETCH;
            ST_ERROR:  state_d = ST_ERROR;
            default:   state_d = ST_ERROR;
        endcase
    end

    // State register; reset aborts any instruction, including memory waits.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    multicycle_out_decode u_out_decode (
        .state       (state_q),
        .mem_ready   (mem_ready),
        .PCWrite     (PCWrite),
        .PCWriteCond (PCWriteCond),
        .IorD        (IorD),
        .MemRead     (MemRead),
        .MemWrite    (MemWrite),
        .IRWrite     (IRWrite),
        .MemtoReg    (MemtoReg),
        .RegDst      (RegDst),
        .RegWrite    (RegWrite),
        .ALUSrcA     (ALUSrcA),
        .ALUSrcB     (ALUSrcB),
        .ALUOp       (ALUOp),
        .PCSource    (PCSource),
        .illegal     (illegal)
    );

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: directed scenarios plus a randomized run,
// each cycle compared against an instruction-sequence reference model.
module tb_multicycle_control;

    localparam int B_PCW  = 16;
    localparam int B_PCWC = 15;
    localparam int B_IORD = 14;
    localparam int B_MRD  = 13;
    localparam int B_MWR  = 12;
    localparam int B_IRW  = 11;
    localparam int B_M2R  = 10;
    localparam int B_RDST = 9;
    localparam int B_RW   = 8;
    localparam int B_ILL  = 0;

    logic       clock = 1'b0;
    logic       reset;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic       MemtoReg, RegDst, RegWrite, ALUSrcA, illegal;
    logic [1:0] ALUSrcB, ALUOp, PCSource;
    logic [3:0] state;
    logic [16:0] ctrl_s;

    int n_checks = 0;
    int n_fail   = 0;

    int          seq[$];
    int          idx;
    logic [5:0]  model_op;
    int          regwr_exp = 0;
    int          regwr_seen = 0;
    logic [3:0]  obs_state;
    logic [16:0] hist[8];

    multicycle_control #(.OPW(6)) dut (
        .clock(clock), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
        .PCSource(PCSource), .illegal(illegal), .state(state)
    );

    assign ctrl_s = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
                     MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp,
                     PCSource, illegal};

    always #5 clock = ~clock;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Control word the specification lists for each state.
    function automatic logic [16:0] exp_ctrl(input int st, input logic mr);
        logic pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, asa, ill;
        logic [1:0] asb, aop, pcs;
        {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, asa, ill} = 11'd0;
        asb = 2'b00; aop = 2'b00; pcs = 2'b00;
        case (st)
            0:  begin mrd = 1'b1; asb = 2'b01; irw = mr; pcw = mr; end
            1:  asb = 2'b11;
            2:  begin asa = 1'b1; asb = 2'b10; end
            3:  begin mrd = 1'b1; iord = 1'b1; end
            4:  begin rw = 1'b1; m2r = 1'b1; end
            5:  begin mwr = 1'b1; iord = 1'b1; end
            6:  begin asa = 1'b1; aop = 2'b10; end
            7:  begin rdst = 1'b1; rw = 1'b1; end
            8:  begin asa = 1'b1; aop = 2'b01; pcwc = 1'b1; pcs = 2'b01; end
            9:  begin pcw = 1'b1; pcs = 2'b10; end
            10: begin asa = 1'b1; asb = 2'b10; end
            11: rw = 1'b1;
            15: ill = 1'b1;
            default: ill = 1'b0;
        endcase
        return {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, asa, asb, aop, pcs, ill};
    endfunction

    // Whole-instruction state walk chosen from the opcode.
    task automatic build_seq(input logic [5:0] op);
        model_op = op;
        case (op)
            6'b000000: seq = '{0, 1, 6, 7};
            6'b100011: seq = '{0, 1, 2, 3, 4};
            6'b101011: seq = '{0, 1, 2, 5};
            6'b000100: seq = '{0, 1, 8};
            6'b000010: seq = '{0, 1, 9};
            6'b001000: seq = '{0, 1, 10, 11};
            default:   seq = '{0, 1, 15};
        endcase
    endtask

    task automatic model_reset();
        seq = '{0};
        idx = 0;
    endtask

    task automatic model_advance(input logic [5:0] op, input logic mr);
        int cur;
        cur = seq[idx];
        if (cur == 15) begin
            idx = idx;
        end else if ((cur == 0 || cur == 3 || cur == 5) && !mr) begin
            idx = idx;
        end else if (cur == 0) begin
            build_seq(op);
            idx = 1;
        end else begin
            idx++;
            if (idx >= seq.size()) begin
                if (model_op == 6'b000000 || model_op == 6'b100011 || model_op == 6'b001000)
                    regwr_exp++;
                model_reset();
            end
        end
    endtask

    task automatic cycle(input logic [5:0] op, input logic mr);
        @(posedge clock);
        #1;
        opcode    = op;
        mem_ready = mr;
        @(negedge clock);
        obs_state = state;
        check_val("state", {28'd0, state}, seq[idx]);
        check_val("ctrl", {15'd0, ctrl_s}, {15'd0, exp_ctrl(seq[idx], mr)});
        if (RegWrite) regwr_seen++;
        model_advance(op, mr);
    endtask

    task automatic pulse_reset(input string tag);
        #2;
        mem_ready = 1'b0;
        reset     = 1'b1;
        #1;
        check_val({tag, "_state"}, {28'd0, state}, 32'd0);
        check_val({tag, "_memwrite"}, {31'd0, MemWrite}, 32'd0);
        check_val({tag, "_illegal"}, {31'd0, illegal}, 32'd0);
        check_val({tag, "_ctrl"}, {15'd0, ctrl_s}, {15'd0, exp_ctrl(0, 1'b0)});
        @(posedge clock);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic run_dir(input string tag, input logic [5:0] op, input int n,
                           input logic [7:0] mrs, input int exps[8]);
        for (int i = 0; i < n; i++) begin
            cycle(op, mrs[i]);
            hist[i] = ctrl_s;
            check_val({tag, "_seq"}, {28'd0, obs_state}, exps[i]);
        end
    endtask

    initial begin
        #20000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        int err_cycles;
        logic [5:0] op;
        logic [5:0] legal_ops[6];
        legal_ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b001000};
        reset = 1'b1; opcode = 6'd0; mem_ready = 1'b0;
        model_reset();
        #12;
        check_val("reset_state", {28'd0, state}, 32'd0);
        check_val("reset_ctrl", {15'd0, ctrl_s}, {15'd0, exp_ctrl(0, 1'b0)});
        @(posedge clock);
        #1;
        reset = 1'b0;

        // R-type: RegWrite and RegDst only in the fourth cycle
        run_dir("rtype", 6'b000000, 5, 8'b00001111, '{0, 1, 6, 7, 0, 0, 0, 0});
        for (int i = 0; i < 5; i++) begin
            check_val("rtype_regwrite", {31'd0, hist[i][B_RW]}, (i == 3) ? 32'd1 : 32'd0);
            check_val("rtype_regdst", {31'd0, hist[i][B_RDST]}, (i == 3) ? 32'd1 : 32'd0);
        end

        // lw with a two-cycle memory stall in MEMRD
        run_dir("lw", 6'b100011, 8, 8'b01100111, '{0, 1, 2, 3, 3, 3, 4, 0});
        cnt = 0;
        for (int i = 0; i < 8; i++) if (hist[i][B_MRD] && hist[i][B_IORD]) cnt++;
        check_val("lw_memread_iord_cycles", cnt, 32'd3);
        check_val("lw_memtoreg", {31'd0, hist[6][B_M2R]}, 32'd1);

        // fetch stall of three cycles followed by a jump
        run_dir("fetchstall", 6'b000010, 7, 8'b00111000, '{0, 0, 0, 0, 1, 9, 0, 0});
        cnt = 0;
        for (int i = 0; i < 4; i++) cnt += hist[i][B_IRW];
        check_val("fetch_irwrite_pulses", cnt, 32'd1);
        check_val("fetch_irwrite_4th", {31'd0, hist[3][B_IRW]}, 32'd1);
        cnt = 0;
        for (int i = 0; i < 4; i++) cnt += hist[i][B_PCW];
        check_val("fetch_pcwrite_pulses", cnt, 32'd1);
        check_val("fetch_pcwrite_4th", {31'd0, hist[3][B_PCW]}, 32'd1);

        // beq
        run_dir("beq", 6'b000100, 4, 8'b00000111, '{0, 1, 8, 0, 0, 0, 0, 0});
        check_val("beq_pcwritecond", {31'd0, hist[2][B_PCWC]}, 32'd1);
        check_val("beq_aluop", {30'd0, hist[2][4:3]}, 32'd1);
        check_val("beq_pcsource", {30'd0, hist[2][2:1]}, 32'd1);
        check_val("beq_pcwrite", {31'd0, hist[2][B_PCW]}, 32'd0);

        // addi
        run_dir("addi", 6'b001000, 5, 8'b00001111, '{0, 1, 10, 11, 0, 0, 0, 0});
        check_val("addi_regwrite", {31'd0, hist[3][B_RW]}, 32'd1);

        // sw aborted by reset during the memory wait
        run_dir("sw", 6'b101011, 5, 8'b00000111, '{0, 1, 2, 5, 5, 0, 0, 0});
        check_val("sw_memwrite_before_reset", {31'd0, MemWrite}, 32'd1);
        pulse_reset("sw_abort");
        cycle(6'b000000, 1'b0);
        check_val("sw_post_reset_state", {28'd0, obs_state}, 32'd0);

        // illegal opcode: sticky ERROR until reset
        run_dir("illegal", 6'b111111, 3, 8'b00000011, '{0, 1, 15, 0, 0, 0, 0, 0});
        for (int i = 0; i < 12; i++) begin
            cycle(6'($urandom_range(0, 63)), 1'($urandom_range(0, 1)));
            check_val("err_state", {28'd0, obs_state}, 32'd15);
            check_val("err_illegal", {31'd0, illegal}, 32'd1);
            check_val("err_wen", {29'd0, RegWrite, MemWrite, PCWrite}, 32'd0);
        end
        pulse_reset("err_reset");

        // randomized instruction stream
        op = 6'd0;
        err_cycles = 0;
        for (int n = 0; n < 1500; n++) begin
            if (seq[idx] == 0) begin
                if ($urandom_range(0, 19) == 0) op = 6'($urandom_range(0, 63));
                else op = legal_ops[$urandom_range(0, 5)];
            end
            cycle(op, ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0);
            if (seq[idx] == 15) err_cycles++;
            if (err_cycles > 4) begin
                pulse_reset("rand_reset");
                err_cycles = 0;
            end
        end

        check_val("regwrite_count", regwr_seen, regwr_exp);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 The block SHALL have parameter OPW, default 6, giving the opcode width.
REQ-002 The block SHALL have port clock, input, 1 bit: the system clock; all state changes occur on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port opcode, input, OPW bits: instr[31:26] from the instruction register.
REQ-005 The block SHALL have port mem_ready, input, 1 bit: memory access completes in the current cycle.
REQ-006 The block SHALL have these 1-bit control outputs: PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA.
REQ-007 The block SHALL have these 2-bit control outputs: ALUSrcB, ALUOp, PCSource.
REQ-008 The block SHALL have port illegal, output, 1 bit: the block is in the ERROR state.
REQ-009 The block SHALL have port state, output, 4 bits: the current state code, for debug.

Function
REQ-010 The block SHALL be a single FSM with states FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, RWB=7, BRANCH=8, JUMP=9, ADDIEX=10, ADDIWB=11, ERROR=15.
REQ-011 Every control output not listed for a state SHALL be 0 in that state.
REQ-012 FETCH SHALL drive MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00.
REQ-013 In FETCH, IRWrite and PCWrite SHALL be 1 only when mem_ready=1.
REQ-014 FETCH SHALL stay in FETCH while mem_ready=0 and SHALL go to DECODE when mem_ready=1.
REQ-015 DECODE SHALL drive ALUSrcA=0, ALUSrcB=11, ALUOp=00.
REQ-016 DECODE SHALL select the next state from opcode: 000000->EXEC, 100011 or 101011->MEMADR, 000100->BRANCH, 000010->JUMP, 001000->ADDIEX, any other->ERROR.
REQ-017 MEMADR SHALL drive ALUSrcA=1, ALUSrcB=10, ALUOp=00, and SHALL go to MEMRD if opcode=100011, else to MEMWR.
REQ-018 MEMRD SHALL drive MemRead=1, IorD=1, SHALL hold while mem_ready=0, and SHALL go to MEMWB when mem_ready=1.
REQ-019 MEMWB SHALL drive RegWrite=1, MemtoReg=1, RegDst=0, and SHALL go to FETCH.
REQ-020 MEMWR SHALL drive MemWrite=1, IorD=1, SHALL hold while mem_ready=0, and SHALL go to FETCH when mem_ready=1.
REQ-021 EXEC SHALL drive ALUSrcA=1, ALUSrcB=00, ALUOp=10, and SHALL go to RWB.
REQ-022 RWB SHALL drive RegDst=1, RegWrite=1, and SHALL go to FETCH.
REQ-023 BRANCH SHALL drive ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01, and SHALL go to FETCH.
REQ-024 JUMP SHALL drive PCWrite=1, PCSource=10, and SHALL go to FETCH.
REQ-025 ADDIEX SHALL drive ALUSrcA=1, ALUSrcB=10, ALUOp=00, and SHALL go to ADDIWB.
REQ-026 ADDIWB SHALL drive RegWrite=1, RegDst=0, MemtoReg=0, and SHALL go to FETCH.
REQ-027 ERROR SHALL be sticky until reset, SHALL drive illegal=1, and SHALL keep every write enable at 0.
REQ-028 RegWrite SHALL be 1 for exactly one cycle per register-writing instruction, and SHALL never be 1 in any other case.
REQ-029 With mem_ready held at 1, instruction latency in cycles SHALL be: R-type 4, lw 5, sw 4, beq 3, j 3, addi 4.
REQ-030 Any state in which the encoding is unused SHALL go to ERROR.

Reset
REQ-031 While reset=1, the state SHALL be FETCH asynchronously.
REQ-032 A reset asserted in any state, including a wait in MEMRD or MEMWR, SHALL abort the instruction immediately.
REQ-033 When the state is forced to FETCH by reset, the outputs SHALL take the FETCH values.
REQ-034 While reset=1, the outputs SHALL have illegal=0 and MemWrite=0.

Structure
REQ-035 A shared package multicycle_pkg SHALL hold the state encodings, the opcode constants, and the ALUOp/ALUSrcB/PCSource constants.
REQ-036 The state register and the next-state logic SHALL be in multicycle_control.
REQ-037 Output decode SHALL be one combinational sub-module, multicycle_out_decode, with inputs state and mem_ready.

Verification
REQ-038 R-type (000000) with mem_ready=1 -> state sequence 0,1,6,7,0; RegWrite=1 and RegDst=1 in the 4th cycle only.
REQ-039 lw (100011) with mem_ready=0 for 2 cycles in MEMRD -> sequence 0,1,2,3,3,3,4,0; MemRead=1 and IorD=1 for 3 cycles; MemtoReg=1 in MEMWB.
REQ-040 FETCH with mem_ready low for 3 cycles -> IRWrite and PCWrite each pulse exactly once, in the 4th FETCH cycle.
REQ-041 beq (000100) -> sequence 0,1,8,0; PCWriteCond=1, ALUOp=01, PCSource=01 in BRANCH; PCWrite=0.
REQ-042 opcode 111111 in DECODE -> state=15, illegal=1, RegWrite=MemWrite=PCWrite=0 for 10+ cycles; reset -> state=0 immediately.
REQ-043 reset pulsed mid-MEMWR (mem_ready=0) -> MemWrite falls before the next clock edge; after reset release the first state is FETCH.
